// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory handshake, aligns stores, extends loads
// and registers the MEM/WB fields. Stalls upstream while a request or response is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        flush_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [2:0]  funct3_m,
  input  logic        RegWrite_m,
  input  logic [1:0]  ResultSrc_m,
  input  logic [4:0]  Rd_m,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  input  logic [31:0] PCPlus4_m,
  input  logic [31:0] ImmExt_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        RegWrite_w,
  output logic [1:0]  ResultSrc_w,
  output logic [4:0]  Rd_w,
  output logic [31:0] ALUResult_w,
  output logic [31:0] load_data_w,
  output logic [31:0] PCPlus4_w,
  output logic [31:0] ImmExt_w
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWaitResp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d, berr_q, berr_d;
  logic            rw_q, rw_d;
  logic [1:0]      rs_q, rs_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     alu_q, alu_d, ld_q, ld_d, pc4_q, pc4_d, imm_q, imm_d;

  logic        mem_op, fresh, live, addr_mis, timeout;
  logic        req, stall, retire, ld_sel;
  logic [1:0]  lane, size;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw, shifted, load_ext;

  assign mem_op   = MemRead_m | MemWrite_m;
  assign fresh    = valid_m & ~flush_m;
  assign live     = fresh & (state_q == StIdle);
  assign lane     = ALUResult_m[1:0];
  assign size     = funct3_m[1:0];
  assign addr_mis = ((size == 2'b01) & lane[0]) | (size[1] & (|lane));
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_raw    = 4'hF;
    wdata_raw = WriteData_m;
    case (size)
      2'b00: begin
        be_raw    = 4'b0001 << lane;
        wdata_raw = {4{WriteData_m[7:0]}};
      end
      2'b01: begin
        be_raw    = 4'b0011 << lane;
        wdata_raw = {2{WriteData_m[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dmem_rdata >> {lane, 3'b000};

  always_comb begin
    case (funct3_m)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    retire  = 1'b0;
    ld_sel  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (live) begin
          if (!mem_op) begin
            retire = 1'b1;
          end else if (addr_mis) begin
            mis_d = 1'b1;
          end else begin
            req = 1'b1;
            if (MemWrite_m) begin
              retire = dmem_ready;
              stall  = ~dmem_ready;
            end else begin
              stall = 1'b1;
              if (dmem_ready) begin
                state_d = StWaitResp;
                cnt_d   = '0;
              end
            end
          end
        end
      end
      StWaitResp: begin
        if (dmem_rvalid) begin
          state_d = StIdle;
          retire  = fresh;
          ld_sel  = fresh;
        end else if (timeout) begin
          state_d = StIdle;
          berr_d  = ~flush_m;
          stall   = ~flush_m;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // A flushed load still owes a response; DRAIN swallows it.
          if (flush_m) state_d = StDrain;
          else         stall   = 1'b1;
        end
      end
      StDrain: begin
        if (dmem_rvalid || timeout) state_d = StIdle;
        else                        cnt_d   = cnt_q + 1'b1;
        if (fresh) begin
          stall  = mem_op;
          retire = ~mem_op;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rw_d  = retire & RegWrite_m;
  assign rs_d  = retire ? ResultSrc_m : 2'b00;
  assign rd_d  = retire ? Rd_m : 5'd0;
  assign alu_d = retire ? ALUResult_m : 32'h0;
  assign pc4_d = retire ? PCPlus4_m : 32'h0;
  assign imm_d = retire ? ImmExt_m : 32'h0;
  assign ld_d  = ld_sel ? load_ext : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      rw_q    <= 1'b0;
      rs_q    <= 2'b00;
      rd_q    <= 5'd0;
      alu_q   <= 32'h0;
      ld_q    <= 32'h0;
      pc4_q   <= 32'h0;
      imm_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
      pc4_q   <= pc4_d;
      imm_q   <= imm_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign dmem_req   = req & ~reset;
  assign mem_stall  = stall & ~reset;
  assign dmem_we    = dmem_req & MemWrite_m;
  assign dmem_addr  = dmem_req ? {ALUResult_m[31:2], 2'b00} : 32'h0;
  assign dmem_be    = dmem_req ? be_raw : 4'h0;
  assign dmem_wdata = dmem_req ? wdata_raw : 32'h0;

  assign misaligned  = mis_q;
  assign bus_error   = berr_q;
  assign RegWrite_w  = rw_q;
  assign ResultSrc_w = rs_q;
  assign Rd_w        = rd_q;
  assign ALUResult_w = alu_q;
  assign load_data_w = ld_q;
  assign PCPlus4_w   = pc4_q;
  assign ImmExt_w    = imm_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TO = 4;
  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, flush_m, MemRead_m, MemWrite_m, RegWrite_m;
  logic [2:0]  funct3_m;
  logic [1:0]  ResultSrc_m;
  logic [4:0]  Rd_m;
  logic [31:0] ALUResult_m, WriteData_m, PCPlus4_m, ImmExt_m;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misaligned, bus_error, RegWrite_w;
  logic [1:0]  ResultSrc_w;
  logic [4:0]  Rd_w;
  logic [31:0] ALUResult_w, load_data_w, PCPlus4_w, ImmExt_w;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .flush_m(flush_m),
    .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m), .funct3_m(funct3_m),
    .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .Rd_m(Rd_m),
    .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .PCPlus4_m(PCPlus4_m),
    .ImmExt_m(ImmExt_m), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .misaligned(misaligned), .bus_error(bus_error), .RegWrite_w(RegWrite_w),
    .ResultSrc_w(ResultSrc_w), .Rd_w(Rd_w), .ALUResult_w(ALUResult_w),
    .load_data_w(load_data_w), .PCPlus4_w(PCPlus4_w), .ImmExt_w(ImmExt_w)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        v, fl, mr, mw;
    logic [2:0]  f3;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4, imm;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall, mis, rw;
  } vec_t;

  function automatic instr_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] wd);
    instr_t t;
    t.v = 1'b1; t.fl = 1'b0; t.mr = mr; t.mw = mw; t.f3 = f3; t.rw = rw; t.rs = rs;
    t.rd = rd; t.alu = alu; t.wd = wd;
    t.pc4 = 32'h1000 + 32'(rd) * 4;
    t.imm = alu ^ 32'hA5A5_0000;
    return t;
  endfunction

  function automatic vec_t mkv(input instr_t in, input logic req, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic stall, input logic mis, input logic rw);
    vec_t v;
    v.in = in; v.req = req; v.we = we; v.be = be; v.wdata = wdata;
    v.stall = stall; v.mis = mis; v.rw = rw;
    return v;
  endfunction

  task automatic present(input instr_t i);
    valid_m = i.v; flush_m = i.fl; MemRead_m = i.mr; MemWrite_m = i.mw; funct3_m = i.f3;
    RegWrite_m = i.rw; ResultSrc_m = i.rs; Rd_m = i.rd; ALUResult_m = i.alu;
    WriteData_m = i.wd; PCPlus4_m = i.pc4; ImmExt_m = i.imm;
  endtask

  task automatic idle_inputs();
    valid_m = 0; flush_m = 0; MemRead_m = 0; MemWrite_m = 0; funct3_m = 0; RegWrite_m = 0;
    ResultSrc_m = 0; Rd_m = 0; ALUResult_m = 0; WriteData_m = 0; PCPlus4_m = 0; ImmExt_m = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Transaction-level reference: what one instruction should look like from outside.
  task automatic model(input instr_t i, input int rdy, input int rv, input logic [31:0] rdata,
                       output int e_stalls, output bit e_mis, output bit e_berr,
                       output bit e_req, output bit e_rw, output bit e_ld,
                       output logic [3:0] e_be, output logic [31:0] e_wd,
                       output logic [31:0] e_data);
    int a, sz;
    bit mem;
    longint unsigned w, p, bytev, half;
    a = int'(i.alu % 4); sz = int'(i.f3 % 4); mem = i.mr | i.mw;
    e_stalls = 0; e_mis = 0; e_berr = 0; e_req = 0; e_rw = 0; e_ld = 0;
    e_be = 0; e_wd = 0; e_data = 0;
    if (!mem) begin
      e_rw = i.rw;
    end else if ((sz == 1 && a % 2 == 1) || (sz >= 2 && a != 0)) begin
      e_mis = 1;
    end else begin
      e_req = 1;
      e_be  = (sz == 0) ? 4'(1 << a) : (sz == 1) ? 4'(3 << a) : 4'hF;
      e_wd  = (sz == 0) ? (i.wd & 32'hFF) * 32'h0101_0101 :
              (sz == 1) ? (i.wd & 32'hFFFF) * 32'h0001_0001 : i.wd;
      if (i.mw) begin
        e_stalls = rdy;
        e_rw = i.rw;
      end else if (rv < int'(TO)) begin
        e_stalls = rdy + 1 + rv;
        e_rw = i.rw;
        e_ld = 1;
        w = rdata;
        p = 64'd1 << (8 * a);
        bytev = (w / p) % 256;
        half = (w / p) % 65536;
        case (i.f3)
          3'd0:    e_data = 32'(bytev >= 128 ? bytev + 64'hFFFF_FF00 : bytev);
          3'd1:    e_data = 32'(half >= 32768 ? half + 64'hFFFF_0000 : half);
          3'd4:    e_data = 32'(bytev);
          3'd5:    e_data = 32'(half);
          default: e_data = rdata;
        endcase
      end else begin
        e_stalls = rdy + 1 + int'(TO);
        e_berr = 1;
      end
    end
  endtask

  // Called at posedge+1. Returns at posedge+1 right after the instruction left MEM.
  task automatic do_txn(input instr_t i, input int rdy, input int rv, input logic [31:0] rdata,
                        output int stalls, output bit mis, output bit berr, output bit req_seen,
                        output bit unstable, output bit done, output logic [3:0] a_be,
                        output logic [31:0] a_wd, output logic [31:0] a_addr,
                        output logic a_we);
    int k, j;
    bit phase, st, have;
    logic [3:0] f_be;
    logic [31:0] f_wd, f_addr;
    logic f_we;
    k = 0; j = 0; phase = 0; have = 0;
    stalls = 0; mis = 0; berr = 0; req_seen = 0; unstable = 0; done = 0;
    a_be = 0; a_wd = 0; a_addr = 0; a_we = 0; f_be = 0; f_wd = 0; f_addr = 0; f_we = 0;
    present(i);
    for (int c = 0; c < 64; c++) begin
      if (!phase) begin
        dmem_ready = (k == rdy); dmem_rvalid = 0; dmem_rdata = $urandom;
      end else begin
        dmem_ready = 0; dmem_rvalid = (j == rv);
        dmem_rdata = (j == rv) ? rdata : $urandom;
      end
      @(negedge clk);
      st = mem_stall;
      if (st) stalls++;
      if (dmem_req) begin
        req_seen = 1;
        if (!have) begin
          have = 1; f_be = dmem_be; f_wd = dmem_wdata; f_addr = dmem_addr; f_we = dmem_we;
        end else if (dmem_be !== f_be || dmem_wdata !== f_wd || dmem_addr !== f_addr ||
                     dmem_we !== f_we) begin
          unstable = 1;
        end
        if (dmem_ready) begin
          a_be = dmem_be; a_wd = dmem_wdata; a_addr = dmem_addr; a_we = dmem_we;
        end
      end
      @(posedge clk); #1;
      if (misaligned) mis = 1;
      if (bus_error) berr = 1;
      if (!st || berr) begin
        done = 1;
        break;
      end
      if (!phase) begin
        if (dmem_ready && i.mr && !i.mw) begin phase = 1; j = 0; end
        else k++;
      end else begin
        j++;
      end
    end
    idle_inputs();
  endtask

  task automatic check_txn(input string nm, input instr_t i, input int rdy, input int rv,
                           input logic [31:0] rdata);
    int e_stalls, stalls;
    bit e_mis, e_berr, e_req, e_rw, e_ld, mis, berr, req_seen, unstable, done;
    logic [3:0] e_be, a_be;
    logic [31:0] e_wd, e_data, a_wd, a_addr;
    logic a_we;
    model(i, rdy, rv, rdata, e_stalls, e_mis, e_berr, e_req, e_rw, e_ld, e_be, e_wd, e_data);
    do_txn(i, rdy, rv, rdata, stalls, mis, berr, req_seen, unstable, done,
           a_be, a_wd, a_addr, a_we);
    chk({nm, " finished"}, done, 1);
    chk({nm, " stall_cycles"}, stalls, e_stalls);
    chk({nm, " misaligned"}, mis, e_mis);
    chk({nm, " bus_error"}, berr, e_berr);
    chk({nm, " req_seen"}, req_seen, e_req);
    chk({nm, " RegWrite_w"}, RegWrite_w, e_rw);
    if (e_req) begin
      chk({nm, " be"}, a_be, e_be);
      chk({nm, " we"}, a_we, i.mw);
      chk({nm, " addr"}, a_addr, i.alu - (i.alu % 4));
      chk({nm, " req_stable"}, unstable, 0);
      if (i.mw) chk({nm, " wdata"}, a_wd, e_wd);
    end
    if (e_rw) begin
      chk({nm, " Rd_w"}, Rd_w, i.rd);
      chk({nm, " ALUResult_w"}, ALUResult_w, i.alu);
      chk({nm, " ResultSrc_w"}, ResultSrc_w, i.rs);
      chk({nm, " PCPlus4_w"}, PCPlus4_w, i.pc4);
      chk({nm, " ImmExt_w"}, ImmExt_w, i.imm);
    end
    if (e_ld) chk({nm, " load_data_w"}, load_data_w, e_data);
  endtask

  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    int kind, rdy, rv;
    logic [2:0] f3;

    vecs[0]  = mkv(mk(0, 0, 3'b000, 1, 2'd0, 5'd5, 32'h10, 0), 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mkv(mk(0, 0, 3'b000, 1, 2'd3, 5'd7, 32'h0, 0), 0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mkv(mk(0, 1, 3'b010, 0, 2'd0, 5'd0, 32'h104, 32'hCAFE_F00D),
                   1, 1, 4'hF, 32'hCAFE_F00D, 0, 0, 0);
    vecs[3]  = mkv(mk(0, 1, 3'b000, 0, 2'd0, 5'd0, 32'h201, 32'h0000_00A5),
                   1, 1, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0);
    vecs[4]  = mkv(mk(0, 1, 3'b000, 0, 2'd0, 5'd0, 32'h203, 32'h0000_0012),
                   1, 1, 4'b1000, 32'h1212_1212, 0, 0, 0);
    vecs[5]  = mkv(mk(0, 1, 3'b001, 0, 2'd0, 5'd0, 32'h200, 32'h5555_BEEF),
                   1, 1, 4'b0011, 32'hBEEF_BEEF, 0, 0, 0);
    vecs[6]  = mkv(mk(0, 1, 3'b001, 0, 2'd0, 5'd0, 32'h202, 32'h0000_7E01),
                   1, 1, 4'b1100, 32'h7E01_7E01, 0, 0, 0);
    vecs[7]  = mkv(mk(1, 0, 3'b010, 1, 2'd1, 5'd8, 32'h101, 0), 0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mkv(mk(1, 0, 3'b001, 1, 2'd1, 5'd8, 32'h103, 0), 0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mkv(mk(1, 0, 3'b101, 1, 2'd1, 5'd8, 32'h105, 0), 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mkv(mk(0, 1, 3'b010, 0, 2'd0, 5'd0, 32'h102, 32'h1), 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mkv(mk(0, 1, 3'b001, 0, 2'd0, 5'd0, 32'h107, 32'h1), 0, 0, 0, 0, 0, 1, 0);
    t = mk(0, 1, 3'b010, 0, 2'd0, 5'd0, 32'h100, 32'h2); t.v = 0;
    vecs[12] = mkv(t, 0, 0, 0, 0, 0, 0, 0);
    t = mk(0, 0, 3'b000, 1, 2'd0, 5'd9, 32'h55, 0); t.fl = 1;
    vecs[13] = mkv(t, 0, 0, 0, 0, 0, 0, 0);
    t = mk(0, 1, 3'b010, 0, 2'd0, 5'd0, 32'h108, 32'h3); t.fl = 1;
    vecs[14] = mkv(t, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    idle_inputs();
    reset = 1;
    #12;
    chk("rst RegWrite_w", RegWrite_w, 0);
    chk("rst ALUResult_w", ALUResult_w, 0);
    chk("rst load_data_w", load_data_w, 0);
    chk("rst Rd_w", Rd_w, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst mem_stall", mem_stall, 0);
    chk("rst misaligned", misaligned, 0);
    chk("rst bus_error", bus_error, 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;

    // Single-cycle vector table
    for (int n = 0; n < NV; n++) begin
      present(vecs[n].in);
      dmem_ready = 1;
      @(negedge clk);
      chk($sformatf("v%0d dmem_req", n), dmem_req, vecs[n].req);
      chk($sformatf("v%0d mem_stall", n), mem_stall, vecs[n].stall);
      if (vecs[n].req) begin
        chk($sformatf("v%0d dmem_we", n), dmem_we, vecs[n].we);
        chk($sformatf("v%0d dmem_be", n), dmem_be, vecs[n].be);
        chk($sformatf("v%0d dmem_wdata", n), dmem_wdata, vecs[n].wdata);
        chk($sformatf("v%0d dmem_addr", n), dmem_addr, {vecs[n].in.alu[31:2], 2'b00});
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d misaligned", n), misaligned, vecs[n].mis);
      chk($sformatf("v%0d RegWrite_w", n), RegWrite_w, vecs[n].rw);
      if (vecs[n].rw) chk($sformatf("v%0d Rd_w", n), Rd_w, vecs[n].in.rd);
    end
    idle_inputs();
    @(posedge clk); #1;
    chk("mis pulse single", misaligned, 0);

    // Loads with extension, delayed store
    check_txn("lb", mk(1, 0, 3'b000, 1, 2'd1, 5'd3, 32'h103, 0), 0, 2, 32'h80FF_0000);
    check_txn("lbu", mk(1, 0, 3'b100, 1, 2'd1, 5'd3, 32'h103, 0), 0, 2, 32'h80FF_0000);
    check_txn("lh", mk(1, 0, 3'b001, 1, 2'd1, 5'd4, 32'h202, 0), 1, 0, 32'h9234_0001);
    check_txn("lw", mk(1, 0, 3'b010, 1, 2'd1, 5'd6, 32'h300, 0), 0, 3, 32'h8765_4321);
    check_txn("sh", mk(0, 1, 3'b001, 0, 2'd0, 5'd0, 32'h102, 32'h1234_ABCD), 2, 0, 0);
    check_txn("sw", mk(0, 1, 3'b010, 0, 2'd0, 5'd0, 32'h104, 32'h0BAD_CAFE), 0, 0, 0);

    // Flush while waiting for a load response
    present(mk(1, 0, 3'b010, 1, 2'd1, 5'd9, 32'h200, 0));
    dmem_ready = 1;
    @(negedge clk);
    chk("fl req", dmem_req, 1);
    chk("fl req_stall", mem_stall, 1);
    @(posedge clk); #1;
    dmem_ready = 0;
    flush_m = 1;
    @(negedge clk);
    chk("fl stall_drop", mem_stall, 0);
    @(posedge clk); #1;
    chk("fl bubble", RegWrite_w, 0);
    present(mk(0, 0, 3'b000, 1, 2'd0, 5'd6, 32'h77, 0));
    @(negedge clk);
    chk("fl drain_alu_stall", mem_stall, 0);
    chk("fl drain_alu_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("fl drain_alu_rw", RegWrite_w, 1);
    chk("fl drain_alu_rd", Rd_w, 6);
    chk("fl drain_alu_res", ALUResult_w, 32'h77);
    present(mk(1, 0, 3'b010, 1, 2'd1, 5'd10, 32'h300, 0));
    @(negedge clk);
    chk("fl drain_mem_stall", mem_stall, 1);
    chk("fl drain_mem_noreq", dmem_req, 0);
    @(posedge clk); #1;
    chk("fl drain_mem_bubble", RegWrite_w, 0);
    dmem_rvalid = 1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fl rvalid_noreq", dmem_req, 0);
    chk("fl rvalid_stall", mem_stall, 1);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("fl discard_rw", RegWrite_w, 0);
    @(negedge clk);
    chk("fl reissue_req", dmem_req, 1);
    idle_inputs();
    @(posedge clk); #1;
    check_txn("fl add", mk(0, 0, 3'b000, 1, 2'd0, 5'd11, 32'h1234, 0), 0, 0, 0);

    // Response timeout
    check_txn("to", mk(1, 0, 3'b010, 1, 2'd1, 5'd12, 32'h80, 0), 0, 99, 0);
    @(posedge clk); #1;
    chk("to pulse single", bus_error, 0);
    check_txn("to add", mk(0, 0, 3'b000, 1, 2'd2, 5'd13, 32'h42, 0), 0, 0, 0);

    // Reset in WAIT_RESP, then a late rvalid in IDLE
    present(mk(1, 0, 3'b000, 1, 2'd1, 5'd4, 32'h40, 0));
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    @(negedge clk);
    chk("rw wait_stall", mem_stall, 1);
    #1;
    reset = 1;
    #1;
    chk("rw stall", mem_stall, 0);
    chk("rw req", dmem_req, 0);
    chk("rw RegWrite_w", RegWrite_w, 0);
    chk("rw ALUResult_w", ALUResult_w, 0);
    chk("rw PCPlus4_w", PCPlus4_w, 0);
    chk("rw bus_error", bus_error, 0);
    idle_inputs();
    reset = 0;
    dmem_rvalid = 1;
    dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rvalid = 0;
    chk("rw late_rvalid_rw", RegWrite_w, 0);
    chk("rw late_rvalid_ld", load_data_w, 0);
    check_txn("rw add", mk(0, 0, 3'b000, 1, 2'd0, 5'd14, 32'h99, 0), 0, 0, 0);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      rdy = int'($urandom_range(0, 3));
      rv = int'($urandom_range(0, 5));
      if (kind == 0) begin
        t = mk(0, 0, 3'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom, 0);
      end else if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        t = mk(1, 0, f3, 1, 2'd1, 5'($urandom), $urandom, $urandom);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        t = mk(0, 1, f3, 0, 2'd0, 5'($urandom), $urandom, $urandom);
      end
      check_txn($sformatf("rnd%0d", n), t, rdy, rv, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
